// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the main control FSM and the mul/div sequencer.
// master: control FSM side (drives req/op/abort) together with the unit flags.
// slave : the sequencer (drives unit starts, HI/LO controls, status and exception).
interface muldiv_sequencer_if #(
  parameter int unsigned CW = 7
);
  logic          req;
  logic          op;
  logic          abort;
  logic          mult_fim;
  logic          div_fim;
  logic          div_zero;
  logic          mult_start;
  logic          div_start;
  logic          hi_sel;
  logic          lo_sel;
  logic          hi_write;
  logic          lo_write;
  logic          busy;
  logic          done;
  logic          exc;
  logic [1:0]    exc_cause;
  logic [CW-1:0] last_cycles;

  modport master (
    output req, op, abort, mult_fim, div_fim, div_zero,
    input  mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
           busy, done, exc, exc_cause, last_cycles
  );

  modport slave (
    input  req, op, abort, mult_fim, div_fim, div_zero,
    output mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
           busy, done, exc, exc_cause, last_cycles
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider: launch, wait for completion,
// commit to HI/LO, or raise a one-cycle exception on divide-by-zero/timeout.
// Ports: clock (rising edge), reset (async, active-low), bus (slave modport:
// req/op/abort and unit flags in; start pulses, HI/LO controls, busy,
// done/exc pulses, exc_cause and last_cycles out).
// MAX_CYCLES must be >= 2 and 2**CW must exceed MAX_CYCLES.
module muldiv_sequencer #(
  parameter int unsigned MAX_CYCLES = 64,
  parameter int unsigned CW         = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_EXC
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_DIVZERO = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t        r_state;
  logic          r_op_q;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;
  logic [CW-1:0] r_last;
  logic          r_mult_start;
  logic          r_div_start;
  logic          r_write;
  logic          r_busy;
  logic          r_done;
  logic          r_exc;
  logic          w_fim;

  // Only the launched unit's completion flag is watched.
  assign w_fim = r_op_q ? bus.div_fim : bus.mult_fim;

  // Single-process FSM; each output register is loaded with the value
  // belonging to the state being entered, so outputs line up with r_state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op_q       <= 1'b0;
      r_cnt        <= '0;
      r_cause      <= CAUSE_NONE;
      r_last       <= '0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_write      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_exc        <= 1'b0;
    end else begin
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_write      <= 1'b0;
      r_done       <= 1'b0;
      r_exc        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_op_q       <= bus.op;
            r_cause      <= CAUSE_NONE;
            r_state      <= S_START;
            r_busy       <= 1'b1;
            r_mult_start <= ~bus.op;
            r_div_start  <= bus.op;
          end
        end
        S_START: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // abort > divide-by-zero > completion > timeout
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_op_q && bus.div_zero) begin
            r_cause <= CAUSE_DIVZERO;
            r_state <= S_EXC;
            r_exc   <= 1'b1;
          end else if (w_fim) begin
            r_last  <= r_cnt;
            r_state <= S_WRITE;
            r_write <= 1'b1;
          end else if (r_cnt == CW'(MAX_CYCLES - 1)) begin
            r_cause <= CAUSE_TIMEOUT;
            r_state <= S_EXC;
            r_exc   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WRITE: begin
          // The write has already happened this cycle; abort only drops done.
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE, S_EXC: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mult_start  = r_mult_start;
  assign bus.div_start   = r_div_start;
  assign bus.hi_sel      = r_op_q;
  assign bus.lo_sel      = r_op_q;
  assign bus.hi_write    = r_write;
  assign bus.lo_write    = r_write;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.exc         = r_exc;
  assign bus.exc_cause   = r_cause;
  assign bus.last_cycles = r_last;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiplier/divider pair on behalf of the main control FSM.
- Launches the selected unit, waits for its completion flag, and commits the result to HI/LO with the correct mux selects.
- Converts divide-by-zero and completion timeouts into a one-cycle exception pulse, and reports latency.
- Lets the main FSM issue one request and wait on a single done/exception pair instead of per-unit handshakes.

Parameters:
- MAX_CYCLES, 64, maximum WAIT cycles before a timeout exception. Must be ≥ 2.
- CW, 7, counter width. Must satisfy 2^CW > MAX_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- req  in  1  start request, sampled only in IDLE.
- op  in  1  operation: 0 = mult, 1 = div. Latched with req.
- abort  in  1  synchronous cancel, honoured in any non-IDLE state.
- mult_fim  in  1  multiplier completion flag.
- div_fim  in  1  divider completion flag.
- div_zero  in  1  divider divide-by-zero flag.
- mult_start  out  1  multiplier start pulse.
- div_start  out  1  divider start pulse.
- hi_sel  out  1  MuxHI select, equals latched op.
- lo_sel  out  1  MuxLO select, equals latched op.
- hi_write  out  1  HI register write enable.
- lo_write  out  1  LO register write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle successful-completion pulse.
- exc  out  1  one-cycle exception pulse.
- exc_cause  out  2  exception cause: 00 none, 01 divide-by-zero, 10 timeout. Held until the next req.
- last_cycles  out  CW  WAIT cycle count of the last successful operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - All outputs = 0, including op_q, counter, exc_cause and last_cycles.
  - Reset mid-operation abandons the operation immediately; no HI/LO write occurs.
- States: IDLE, START, WAIT, WRITE, DONE, EXC. All outputs are decoded from registered state, op_q and cause.
- IDLE:
  - On req=1: op_q←op, exc_cause←00, go to START.
  - req in any other state is ignored; there is no queueing.
- START (1 cycle):
  - mult_start = ~op_q, div_start = op_q.
  - Counter←0, go to WAIT.
- WAIT:
  - Watched flag fim = op_q ? div_fim : mult_fim. The other unit's flags are ignored.
  - Priority in one cycle: abort > (op_q & div_zero) > fim > timeout.
  - op_q=1 & div_zero=1: cause←01, go to EXC. This wins even if div_fim=1 in the same cycle.
  - fim=1: last_cycles←counter, go to WRITE.
  - counter == MAX_CYCLES-1 with no fim: cause←10, go to EXC.
  - Otherwise: counter←counter+1. The counter never wraps.
- WRITE (1 cycle):
  - hi_write = lo_write = 1.
  - Go to DONE.
- DONE (1 cycle):
  - done = 1.
  - Go to IDLE.
- EXC (1 cycle):
  - exc = 1, no HI/LO writes.
  - Go to IDLE.
- abort=1 in START, WAIT, DONE or EXC:
  - Next state IDLE; no done or exc is produced afterwards.
  - From DONE or EXC, the current-cycle pulse has already been driven.
- abort in WRITE:
  - The write completes in that cycle, then the block goes to IDLE without a done pulse.
- hi_sel and lo_sel:
  - Track op_q while busy and hold their value in IDLE.
  - They equal op_q during the WRITE cycle.
- Latency with fim on the k-th WAIT cycle (k ≥ 1):
  - req at cycle 0, START at 1, WAIT at 2..k+1, WRITE at k+2, done at k+3.
  - last_cycles = k-1.
- busy:
  - Rises the cycle after req is accepted and falls on return to IDLE.
  - req may be issued in the cycle after done or exc.

Test Plan:
- Mult: req=1, op=0; mult_fim on the 33rd WAIT cycle -> mult_start high exactly 1 cycle, div_start stays 0, hi_write=lo_write=1 with hi_sel=lo_sel=0 for 1 cycle, done at cycle 36, last_cycles=32, busy low at cycle 37.
- Div by zero: req, op=1; div_zero=1 and div_fim=1 together on the 3rd WAIT cycle -> exc=1 one cycle, exc_cause=01, no hi_write/lo_write, done stays 0.
- Timeout: req, op=1, MAX_CYCLES=64, no div_fim -> exc after exactly 64 WAIT cycles, exc_cause=10, counter holds at 63.
- Abort: assert abort on the 5th WAIT cycle -> IDLE next cycle, no write, no done/exc; a new req the following cycle is accepted and completes normally.
- Reset mid-WAIT: pull reset=0 asynchronously mid-WAIT -> all outputs 0 before the next edge; release reset and a subsequent req runs a full operation.
- Req while busy: pulse req with op=1 during a mult WAIT -> ignored; hi_sel stays 0, and exactly one done is produced.
